// File: rtl/scheduler1_commit_pkg.sv
`default_nettype none
// ============================================================================
// scheduler1_commit_pkg : shared sizes and pointer helper for the commit buffer
// Rev 1.0
// ============================================================================
package scheduler1_commit_pkg;

  localparam int COMMIT_DEPTH   = 64;
  localparam int PTR_W          = 6;
  localparam int FULL_THRESHOLD = 62;

  // Pointer arithmetic relies on PTR_W-bit truncation for the mod-depth wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                               input logic [1:0]       n);
    return ptr + PTR_W'(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scheduler1_commit_select.sv
`default_nettype none
// ============================================================================
// scheduler1_commit_select : head/head+1 readiness and commit strobe generation
// Rev 1.0
// ============================================================================
module scheduler1_commit_select
  import scheduler1_commit_pkg::*;
(
  input  logic [PTR_W-1:0]        head,
  input  logic [PTR_W:0]          count,
  input  logic                    flush,
  input  logic [COMMIT_DEPTH-1:0] info_valid,
  input  logic [COMMIT_DEPTH-1:0] info_ex_end,
  input  logic [COMMIT_DEPTH-1:0] info_branch,
  output logic                    c0,
  output logic                    c1,
  output logic [PTR_W-1:0]        tag0,
  output logic [PTR_W-1:0]        tag1,
  output logic [COMMIT_DEPTH-1:0] vector
);

  logic [PTR_W-1:0] head1;
  logic             ready0;
  logic             ready1;

  always_comb begin
    head1  = ptr_inc(head, 2'd1);
    ready0 = info_valid[head]  && info_ex_end[head];
    ready1 = info_valid[head1] && info_ex_end[head1];
    // A branch at the head retires alone so redirect handling sees it last.
    c0     = !flush && (count != '0) && ready0;
    c1     = c0 && (count >= (PTR_W+1)'(2)) && !info_branch[head] && ready1;
    tag0   = flush ? '0 : head;
    tag1   = flush ? '0 : head1;
    vector = '0;
    for (int i = 0; i < COMMIT_DEPTH; i++) begin
      vector[i] = (c0 && (head == PTR_W'(i))) || (c1 && (head1 == PTR_W'(i)));
    end
  end

endmodule
`default_nettype wire

// File: rtl/scheduler1_commit_ctrl.sv
`default_nettype none
// ============================================================================
// scheduler1_commit_ctrl : in-order dual-retire commit controller (head/tail/count)
// Rev 1.0
// ============================================================================
module scheduler1_commit_ctrl
  import scheduler1_commit_pkg::*;
#(
  parameter int COMMIT_DEPTH = 64,
  parameter int PTR_W        = 6
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iLOCK,
  input  logic                    iRESTART_VALID,
  input  logic                    iREGIST_0_VALID,
  input  logic                    iREGIST_1_VALID,
  output logic [PTR_W-1:0]        oREGIST_POINTER,
  output logic                    oFULL,
  output logic                    oEMPTY,
  output logic [PTR_W:0]          oCOUNT,
  input  logic [COMMIT_DEPTH-1:0] iINFO_VALID,
  input  logic [COMMIT_DEPTH-1:0] iINFO_EX_END,
  input  logic [COMMIT_DEPTH-1:0] iINFO_EX_BRANCH,
  output logic [COMMIT_DEPTH-1:0] oCOMMIT_VALID_VECTOR,
  output logic                    oCOMMIT_0_VALID,
  output logic [PTR_W-1:0]        oCOMMIT_0_TAG,
  output logic                    oCOMMIT_1_VALID,
  output logic [PTR_W-1:0]        oCOMMIT_1_TAG
);

  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             full;
  logic             empty;
  logic             flush;
  logic             accept;
  logic             c0;
  logic             c1;
  logic [1:0]       n_reg;
  logic [1:0]       n_com;

  // Commit strobes must stay quiet while either reset or restart is asserted.
  assign flush = iRESTART_VALID || !inRESET;

  scheduler1_commit_select u_select (
    .head        (head),
    .count       (count),
    .flush       (flush),
    .info_valid  (iINFO_VALID),
    .info_ex_end (iINFO_EX_END),
    .info_branch (iINFO_EX_BRANCH),
    .c0          (c0),
    .c1          (c1),
    .tag0        (oCOMMIT_0_TAG),
    .tag1        (oCOMMIT_1_TAG),
    .vector      (oCOMMIT_VALID_VECTOR)
  );

  always_comb begin
    accept     = iREGIST_0_VALID && !iLOCK && !full && !iRESTART_VALID;
    n_reg      = accept ? (iREGIST_1_VALID ? 2'd2 : 2'd1) : 2'd0;
    n_com      = {1'b0, c0} + {1'b0, c1};
    count_next = count + (PTR_W+1)'(n_reg) - (PTR_W+1)'(n_com);
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET || iRESTART_VALID) begin
      tail  <= '0;
      head  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      tail  <= ptr_inc(tail, n_reg);
      head  <= ptr_inc(head, n_com);
      count <= count_next;
      // Threshold leaves room for a full pair, so upstream never splits one.
      full  <= count_next > (PTR_W+1)'(FULL_THRESHOLD);
      empty <= count_next == '0;
    end
  end

  assign oREGIST_POINTER = tail;
  assign oCOUNT          = count;
  assign oFULL           = full;
  assign oEMPTY          = empty;
  assign oCOMMIT_0_VALID = c0;
  assign oCOMMIT_1_VALID = c1;

endmodule
`default_nettype wire

// File: tb/tb_scheduler1_commit_ctrl.sv
`default_nettype none
// ============================================================================
// tb_scheduler1_commit_ctrl : directed scoreboard bench for the commit controller
// Rev 1.0
// ============================================================================
module tb_scheduler1_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock;
  logic        restart;
  logic        reg0;
  logic        reg1;
  logic [63:0] info_valid;
  logic [63:0] info_ex_end;
  logic [63:0] info_branch;
  logic [5:0]  regist_pointer;
  logic        full;
  logic        empty;
  logic [6:0]  count;
  logic [63:0] vector;
  logic        c0_valid;
  logic [5:0]  c0_tag;
  logic        c1_valid;
  logic [5:0]  c1_tag;

  always #5 clk = ~clk;

  scheduler1_commit_ctrl dut (
    .iCLOCK               (clk),
    .inRESET              (rst_n),
    .iLOCK                (lock),
    .iRESTART_VALID       (restart),
    .iREGIST_0_VALID      (reg0),
    .iREGIST_1_VALID      (reg1),
    .oREGIST_POINTER      (regist_pointer),
    .oFULL                (full),
    .oEMPTY               (empty),
    .oCOUNT               (count),
    .iINFO_VALID          (info_valid),
    .iINFO_EX_END         (info_ex_end),
    .iINFO_EX_BRANCH      (info_branch),
    .oCOMMIT_VALID_VECTOR (vector),
    .oCOMMIT_0_VALID      (c0_valid),
    .oCOMMIT_0_TAG        (c0_tag),
    .oCOMMIT_1_VALID      (c1_valid),
    .oCOMMIT_1_TAG        (c1_tag)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_bad++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; lock = 1'b0; restart = 1'b0; reg0 = 1'b0; reg1 = 1'b0;
    info_valid = '0; info_ex_end = '0; info_branch = '0;
    tick(); tick();

    // Reset state, with every entry claiming done to exercise count gating
    info_valid = '1; info_ex_end = '1; reg0 = 1'b1;
    push("rst_ptr", 0); push("rst_cnt", 0); push("rst_empty", 1);
    push("rst_full", 0); push("rst_c0", 0); push("rst_vec", 0);
    smp();
    pop_chk("rst_ptr", 64'(regist_pointer)); pop_chk("rst_cnt", 64'(count));
    pop_chk("rst_empty", 64'(empty)); pop_chk("rst_full", 64'(full));
    pop_chk("rst_c0", 64'(c0_valid)); pop_chk("rst_vec", vector);
    rst_n = 1'b1; reg0 = 1'b0; info_valid = '0; info_ex_end = '0;
    tick();

    // Fill with 32 pairs, no execution completing
    for (int i = 0; i < 32; i++) begin
      reg0 = 1'b1; reg1 = 1'b1;
      if (i == 31) begin
        push("fill_cnt62", 62); push("fill_full62", 0);
        smp();
        pop_chk("fill_cnt62", 64'(count)); pop_chk("fill_full62", 64'(full));
      end
      tick();
    end
    reg1 = 1'b0;
    push("full_ptr", 0); push("full_cnt", 64); push("full_flag", 1); push("full_empty", 0);
    smp();
    pop_chk("full_ptr", 64'(regist_pointer)); pop_chk("full_cnt", 64'(count));
    pop_chk("full_flag", 64'(full)); pop_chk("full_empty", 64'(empty));
    tick();
    reg0 = 1'b0;
    push("refuse_cnt", 64); push("refuse_ptr", 0);
    smp();
    pop_chk("refuse_cnt", 64'(count)); pop_chk("refuse_ptr", 64'(regist_pointer));
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // Dual commit of entries 0 and 1
    reg0 = 1'b1; reg1 = 1'b1; tick();
    reg0 = 1'b0; reg1 = 1'b0;
    info_valid[1:0] = 2'b11; info_ex_end[1:0] = 2'b11;
    push("dual_c0", 1); push("dual_tag0", 0); push("dual_c1", 1);
    push("dual_tag1", 1); push("dual_vec", 64'h3); push("dual_cnt", 2);
    smp();
    pop_chk("dual_c0", 64'(c0_valid)); pop_chk("dual_tag0", 64'(c0_tag));
    pop_chk("dual_c1", 64'(c1_valid)); pop_chk("dual_tag1", 64'(c1_tag));
    pop_chk("dual_vec", vector); pop_chk("dual_cnt", 64'(count));
    tick();
    info_valid = '0; info_ex_end = '0;
    push("dual_cnt_after", 0); push("dual_empty", 1);
    smp();
    pop_chk("dual_cnt_after", 64'(count)); pop_chk("dual_empty", 64'(empty));
    tick();

    // Walk head to 5 with registration and commit overlapping
    reg0 = 1'b1; reg1 = 1'b1; tick();
    reg1 = 1'b0;
    info_valid[3:2] = 2'b11; info_ex_end[3:2] = 2'b11;
    push("ovl_c1", 1);
    smp();
    pop_chk("ovl_c1", 64'(c1_valid));
    tick();
    info_valid[3:2] = 2'b00; info_ex_end[3:2] = 2'b00;
    reg1 = 1'b1;
    info_valid[5:4] = 2'b11; info_ex_end[5:4] = 2'b11;
    push("ovl_cnt", 1); push("one_tag0", 4); push("one_c1", 0);
    smp();
    pop_chk("ovl_cnt", 64'(count)); pop_chk("one_tag0", 64'(c0_tag));
    pop_chk("one_c1", 64'(c1_valid));
    tick();
    info_valid[4] = 1'b0; info_ex_end[4] = 1'b0;

    // Branch at head retires alone
    reg0 = 1'b0; reg1 = 1'b0;
    info_valid[6] = 1'b1; info_ex_end[6] = 1'b1; info_branch[5] = 1'b1;
    push("br_c0", 1); push("br_tag0", 5); push("br_c1", 0);
    push("br_vec", 64'h20); push("br_cnt", 2);
    smp();
    pop_chk("br_c0", 64'(c0_valid)); pop_chk("br_tag0", 64'(c0_tag));
    pop_chk("br_c1", 64'(c1_valid)); pop_chk("br_vec", vector);
    pop_chk("br_cnt", 64'(count));
    tick();
    info_valid[5] = 1'b0; info_ex_end[5] = 1'b0; info_branch[5] = 1'b0;
    push("br2_c0", 1); push("br2_tag0", 6); push("br2_vec", 64'h40);
    smp();
    pop_chk("br2_c0", 64'(c0_valid)); pop_chk("br2_tag0", 64'(c0_tag));
    pop_chk("br2_vec", vector);
    tick();
    info_valid[6] = 1'b0; info_ex_end[6] = 1'b0;

    // Stream pairs until head sits at 63 with 63 and 0 not yet done
    info_valid = '1; info_ex_end = '1; info_ex_end[63] = 1'b0; info_ex_end[0] = 1'b0;
    reg0 = 1'b1; reg1 = 1'b1;
    for (int k = 0; k < 29; k++) tick();
    reg0 = 1'b0; reg1 = 1'b0;
    push("wrap_ptr", 1); push("wrap_cnt", 2); push("wrap_wait_c0", 0);
    smp();
    pop_chk("wrap_ptr", 64'(regist_pointer)); pop_chk("wrap_cnt", 64'(count));
    pop_chk("wrap_wait_c0", 64'(c0_valid));
    tick();
    info_ex_end[63] = 1'b1; info_ex_end[0] = 1'b1;
    push("wrap_c0", 1); push("wrap_tag0", 63); push("wrap_c1", 1);
    push("wrap_tag1", 0); push("wrap_vec", (64'd1 << 63) | 64'd1);
    smp();
    pop_chk("wrap_c0", 64'(c0_valid)); pop_chk("wrap_tag0", 64'(c0_tag));
    pop_chk("wrap_c1", 64'(c1_valid)); pop_chk("wrap_tag1", 64'(c1_tag));
    pop_chk("wrap_vec", vector);
    tick();
    push("wrap_cnt0", 0); push("empty_no_c0", 0);
    smp();
    pop_chk("wrap_cnt0", 64'(count)); pop_chk("empty_no_c0", 64'(c0_valid));
    tick();

    // Lock with pending commits and a register request
    reg0 = 1'b1; reg1 = 1'b1; tick();
    lock = 1'b1;
    push("lock_c0", 1); push("lock_tag0", 1); push("lock_c1", 1);
    push("lock_tag1", 2); push("lock_ptr", 3);
    smp();
    pop_chk("lock_c0", 64'(c0_valid)); pop_chk("lock_tag0", 64'(c0_tag));
    pop_chk("lock_c1", 64'(c1_valid)); pop_chk("lock_tag1", 64'(c1_tag));
    pop_chk("lock_ptr", 64'(regist_pointer));
    tick();
    lock = 1'b0; reg0 = 1'b0; reg1 = 1'b0;
    push("lock_ptr_held", 3); push("lock_cnt", 0);
    smp();
    pop_chk("lock_ptr_held", 64'(regist_pointer)); pop_chk("lock_cnt", 64'(count));
    tick();

    // Restart with ten entries in flight
    info_valid = '0; info_ex_end = '0;
    reg0 = 1'b1; reg1 = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    reg1 = 1'b0; restart = 1'b1; info_valid = '1; info_ex_end = '1;
    push("rs_cnt", 10); push("rs_c0", 0); push("rs_c1", 0);
    push("rs_vec", 0); push("rs_tag0", 0);
    smp();
    pop_chk("rs_cnt", 64'(count)); pop_chk("rs_c0", 64'(c0_valid));
    pop_chk("rs_c1", 64'(c1_valid)); pop_chk("rs_vec", vector);
    pop_chk("rs_tag0", 64'(c0_tag));
    tick();
    restart = 1'b0; reg0 = 1'b0; info_valid = '0; info_ex_end = '0;
    push("rs_ptr", 0); push("rs_cnt0", 0); push("rs_empty", 1);
    smp();
    pop_chk("rs_ptr", 64'(regist_pointer)); pop_chk("rs_cnt0", 64'(count));
    pop_chk("rs_empty", 64'(empty));
    tick();

    // Reset asserted mid-stream
    reg0 = 1'b1; reg1 = 1'b1; tick();
    info_valid = '1; info_ex_end = '1; rst_n = 1'b0;
    push("mr_c0", 0); push("mr_vec", 0);
    smp();
    pop_chk("mr_c0", 64'(c0_valid)); pop_chk("mr_vec", vector);
    tick();
    rst_n = 1'b1; reg0 = 1'b0; reg1 = 1'b0; info_valid = '0; info_ex_end = '0;
    push("mr_ptr", 0); push("mr_cnt", 0); push("mr_empty", 1); push("mr_full", 0);
    smp();
    pop_chk("mr_ptr", 64'(regist_pointer)); pop_chk("mr_cnt", 64'(count));
    pop_chk("mr_empty", 64'(empty)); pop_chk("mr_full", 64'(full));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
